vga_fb_loader: RTL and testbench
================================

Name: vga_fb_loader

Overview:
- Upstream stage of the VGA frame buffer. Accepts a raw pixel byte stream (from a UART/DMA source) on a valid/ready handshake.
- Assembles bytes into DATA_WIDTH-bit pixels and generates sequential word-addressed frame buffer writes (addr = pixel_index*4).
- Buffers writes in a small FIFO so frame buffer stalls do not drop bytes. Signals end-of-frame.

Parameters:
- ADDR_WIDTH, 32, width of the write address.
- DATA_WIDTH, 24, pixel width; 24 = RGB888 (3 bytes/pixel), 8 = gray (1 byte/pixel); no other values are legal.
- IMG_WIDTH, 48, image width in pixels.
- IMG_HEIGHT, 48, image height in pixels.
- FIFO_DEPTH, 4, pending-write FIFO entries; must be a power of 2 and at least 2.

Ports:
- ahb_clk  input  1  single clock for the whole block.
- rst  input  1  synchronous reset, active-high.
- s_valid  input  1  source byte valid.
- s_data  input  8  source byte.
- s_sof  input  1  start of frame; qualified by s_valid, marks the first byte of a frame.
- s_ready  output  1  block can accept a byte this cycle.
- wr_en  output  1  frame buffer write request.
- wr_addr  output  ADDR_WIDTH  byte address of the write (pixel_index << 2).
- wr_data  output  DATA_WIDTH  pixel value.
- wr_stall  input  1  frame buffer cannot accept the write this cycle.
- frame_done  output  1  one-cycle pulse when the last pixel of a frame is pushed into the FIFO.
- pix_count  output  $clog2(IMG_WIDTH*IMG_HEIGHT)  index of the next pixel to assemble.

Behaviour:
- Reset values, applied on the clock edge while rst=1: s_ready=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, pix_count=0. FIFO emptied; byte_idx=0; partial pixel cleared.
- After rst is released, s_ready = !fifo_full. It is registered-free combinational from the FIFO count.
- Byte accept: a byte is accepted when s_valid && s_ready.
- Assembly order for DATA_WIDTH=24: byte_idx 0 → bits [23:16] (R), byte_idx 1 → [15:8] (G), byte_idx 2 → [7:0] (B).
- The push happens on acceptance of byte_idx 2, using that byte directly. byte_idx then returns to 0.
- DATA_WIDTH=8: every accepted byte is a full pixel and is pushed immediately.
- Push contents: {pixel, pix_count<<2}. After the push, pix_count increments. At N-1 (N = IMG_WIDTH*IMG_HEIGHT) it wraps to 0 and frame_done pulses in the cycle following that push.
- s_sof accepted with a byte: byte_idx and pix_count are forced to 0 before that byte is used, and any partial pixel is discarded. The byte becomes byte 0 of pixel 0 at address 0.
- s_sof while s_valid=0 is ignored.
- Write side: wr_en = !fifo_empty. wr_addr and wr_data come from the FIFO head.
- The head is popped when wr_en && !wr_stall.
- While stalled, wr_en, wr_addr and wr_data hold stable.
- Latency: the final byte of a pixel is accepted in cycle t. With the FIFO empty, wr_en=1 with that pixel in cycle t+1 (registered FIFO). Sustained throughput is 1 pixel per cycle for gray and 1 pixel per 3 cycles for RGB.
- Full: s_ready=0, and no byte is consumed, so there is no overflow path. A pop in the same cycle frees space, and s_ready rises in the next cycle.
- Empty: wr_en=0, and wr_stall is ignored.
- Simultaneous push and pop with the FIFO not full: both occur, and the count is unchanged.
- Reset mid-frame or mid-stall: pending writes are dropped and wr_en falls the cycle after rst is sampled. The next frame must start with s_sof or restart at pixel 0.

Optional Feature:
- Macro VGA_FB_LOADER_CHECKSUM_EN.
- Defined: adds output port frame_csum [15:0]. It is a running mod-2^16 sum of every accepted byte in the current frame.
- On frame_done, frame_csum is latched into frame_csum and the accumulator clears. An accepted s_sof also clears the accumulator, and that byte starts the new sum.
- frame_csum resets to 0.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- RGB frame, wr_stall=0: stream bytes 0x11,0x22,0x33 then 0x44,0x55,0x66 with s_sof on the first byte → wr_en for two cycles with (addr 0x0, data 0x112233) then (addr 0x4, data 0x445566); pix_count=2.
- Full 48x48 RGB frame (6912 bytes) → 2304 writes, last at addr 0x23FC. frame_done pulses exactly once, the cycle after the final push, and pix_count returns to 0.
- Hold wr_stall=1 with FIFO_DEPTH=4, streaming continuously → after 4 pixels s_ready=0, and wr_en/addr/data stay fixed at pixel 0. Release the stall → writes drain in order and no byte is lost.
- Send 2 bytes of a pixel, then s_sof with byte 0xAA followed by 0xBB,0xCC → the partial pixel is discarded; the next write is addr 0x0, data 0xAABBCC.
- Assert rst for one cycle while 3 writes are pending and stalled → next cycle wr_en=0, s_ready=1, pix_count=0; a following 3-byte pixel is written to addr 0x0.
- DATA_WIDTH=8 with bytes 0x01..0x04 back-to-back → writes at addr 0x0,0x4,0x8,0xC with data 0x01..0x04. With the checksum macro defined, a full frame of 0x01 bytes gives frame_csum=0x0900.

Source files
------------

// File: rtl/vga_fb_loader.sv
// vga_fb_loader: turns a valid/ready byte stream into frame buffer pixel writes.
// Bytes are packed into DATA_WIDTH-bit pixels (24 = RGB888, 8 = gray). Each
// finished pixel goes into a small write FIFO together with its byte address
// (pixel_index*4). The FIFO absorbs frame buffer stalls. frame_done pulses
// after the last pixel of a frame has been queued.
// Optional macro VGA_FB_LOADER_CHECKSUM_EN adds frame_csum, a 16-bit sum of
// all bytes in the last completed frame.
module vga_fb_loader #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 24,
  parameter  int IMG_WIDTH  = 48,
  parameter  int IMG_HEIGHT = 48,
  parameter  int FIFO_DEPTH = 4,
  localparam int PIX_W      = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                  ahb_clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  input  logic                  s_sof,
  output logic                  s_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_stall,
  output logic                  frame_done,
  output logic [PIX_W-1:0]      pix_count
`ifdef VGA_FB_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]           frame_csum
`endif
);

  localparam int NPIX    = IMG_WIDTH * IMG_HEIGHT;
  localparam int BPP     = DATA_WIDTH / 8;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W:0]        count_q;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_head;

  // Pixel assembly state
  logic [1:0]            byte_idx_q;
  logic [1:0]            byte_idx_eff;
  logic [PIX_W-1:0]      pix_count_q;
  logic [PIX_W-1:0]      pix_eff;
  logic                  frame_done_q;
  logic                  accept;
  logic                  last_byte;
  logic                  last_pixel;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] pixel_d;
  logic [ADDR_WIDTH-1:0] push_addr;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
  assign s_ready    = !rst && !fifo_full;
  assign accept     = s_valid && s_ready;

  // An accepted start-of-frame byte restarts both the byte and pixel position,
  // which also throws away any half-built pixel.
  assign byte_idx_eff = s_sof ? 2'd0 : byte_idx_q;
  assign pix_eff      = s_sof ? '0 : pix_count_q;
  assign last_byte    = (byte_idx_eff == 2'(BPP - 1));
  assign last_pixel   = (pix_eff == PIX_W'(NPIX - 1));
  assign push         = accept && last_byte;
  assign pop          = !fifo_empty && !wr_stall;
  assign push_addr    = ADDR_WIDTH'(pix_eff) << 2;

  generate
    if (DATA_WIDTH == 24) begin : g_rgb
      logic [15:0] part_q;

      // Hold R and G until B arrives; B is used straight from the input.
      always_ff @(posedge ahb_clk) begin
        if (rst) begin
          part_q <= '0;
        end else if (accept && byte_idx_eff == 2'd0) begin
          part_q <= {s_data, 8'h00};
        end else if (accept && byte_idx_eff == 2'd1) begin
          part_q[7:0] <= s_data;
        end
      end

      assign pixel_d = {part_q, s_data};
    end else begin : g_gray
      assign pixel_d = DATA_WIDTH'(s_data);
    end
  endgenerate

  // Byte position, pixel index and end-of-frame pulse.
  always_ff @(posedge ahb_clk) begin
    if (rst) begin
      byte_idx_q   <= 2'd0;
      pix_count_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (accept) begin
        if (last_byte) begin
          byte_idx_q <= 2'd0;
          if (last_pixel) begin
            pix_count_q  <= '0;
            frame_done_q <= 1'b1;
          end else begin
            pix_count_q <= pix_eff + 1'b1;
          end
        end else begin
          byte_idx_q  <= byte_idx_eff + 2'd1;
          pix_count_q <= pix_eff;
        end
      end
    end
  end

  // FIFO payload write; storage needs no reset since occupancy gates the read.
  always_ff @(posedge ahb_clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {pixel_d, push_addr};
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge ahb_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head entry drives the write port; outputs read as zero while nothing is pending.
  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  assign wr_en      = !fifo_empty;
  assign wr_addr    = wr_en ? fifo_head[ADDR_WIDTH-1:0] : '0;
  assign wr_data    = wr_en ? fifo_head[ENTRY_W-1:ADDR_WIDTH] : '0;
  assign frame_done = frame_done_q;
  assign pix_count  = pix_count_q;

`ifdef VGA_FB_LOADER_CHECKSUM_EN
  logic [15:0] csum_acc_q;
  logic [15:0] frame_csum_q;
  logic [15:0] csum_sum;

  assign csum_sum = (s_sof ? 16'h0000 : csum_acc_q) + {8'h00, s_data};

  // Running byte sum; latched out and restarted when the frame's last pixel is queued.
  always_ff @(posedge ahb_clk) begin
    if (rst) begin
      csum_acc_q   <= 16'h0000;
      frame_csum_q <= 16'h0000;
    end else if (accept) begin
      if (push && last_pixel) begin
        frame_csum_q <= csum_sum;
        csum_acc_q   <= 16'h0000;
      end else begin
        csum_acc_q <= csum_sum;
      end
    end
  end

  assign frame_csum = frame_csum_q;
`endif

endmodule

// File: tb/tb_vga_fb_loader.sv
// Bench for vga_fb_loader: an RGB instance checked every cycle against a
// queue-based reference model, plus a gray instance with directed stimulus.
module tb_vga_fb_loader;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int NPIX  = 48 * 48;

  logic ahb_clk = 1'b0;
  always #5 ahb_clk = ~ahb_clk;

  // RGB instance signals
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_sof = 1'b0;
  logic          wr_stall = 1'b0;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          frame_done;
  logic [11:0]   pix_count;

  // Gray instance signals
  logic          g_rst = 1'b1;
  logic          g_valid = 1'b0;
  logic [7:0]    g_data = 8'h00;
  logic          g_sof = 1'b0;
  logic          g_stall = 1'b0;
  logic          g_ready;
  logic          g_wr_en;
  logic [AW-1:0] g_wr_addr;
  logic [7:0]    g_wr_data;
  logic          g_frame_done;
  logic [11:0]   g_pix_count;

`ifdef VGA_FB_LOADER_CHECKSUM_EN
  logic [15:0]   frame_csum;
  logic [15:0]   g_frame_csum;
`endif

  vga_fb_loader u_rgb (
    .ahb_clk    (ahb_clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_sof      (s_sof),
    .s_ready    (s_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_stall   (wr_stall),
    .frame_done (frame_done),
    .pix_count  (pix_count)
`ifdef VGA_FB_LOADER_CHECKSUM_EN
    ,
    .frame_csum (frame_csum)
`endif
  );

  vga_fb_loader #(.DATA_WIDTH(8)) u_gray (
    .ahb_clk    (ahb_clk),
    .rst        (g_rst),
    .s_valid    (g_valid),
    .s_data     (g_data),
    .s_sof      (g_sof),
    .s_ready    (g_ready),
    .wr_en      (g_wr_en),
    .wr_addr    (g_wr_addr),
    .wr_data    (g_wr_data),
    .wr_stall   (g_stall),
    .frame_done (g_frame_done),
    .pix_count  (g_pix_count)
`ifdef VGA_FB_LOADER_CHECKSUM_EN
    ,
    .frame_csum (g_frame_csum)
`endif
  );

  // Reference model: queue of pending writes plus the current frame position.
  typedef struct {
    logic [31:0] addr;
    logic [23:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         m_bcnt = 0;
  int         m_pix = 0;
  logic [7:0] m_bytes[3];
  bit         m_fd = 1'b0;
  bit         m_after_rst = 1'b0;
  int         m_csum_acc = 0;
  int         m_csum_frame = 0;
  int         dut_fd_count = 0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every RGB output against the model state after the latest edge.
  task automatic check_outputs();
    check_eq("s_ready", s_ready, (!rst && exp_q.size() < DEPTH));
    check_eq("wr_en", wr_en, (exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_eq("wr_addr", wr_addr, exp_q[0].addr);
      check_eq("wr_data", wr_data, exp_q[0].data);
    end else if (m_after_rst) begin
      check_eq("wr_addr_rst", wr_addr, 0);
      check_eq("wr_data_rst", wr_data, 0);
    end
    check_eq("frame_done", frame_done, m_fd);
    check_eq("pix_count", pix_count, m_pix);
`ifdef VGA_FB_LOADER_CHECKSUM_EN
    check_eq("frame_csum", frame_csum, m_csum_frame);
`endif
    if (frame_done) dut_fd_count++;
  endtask

  // One RGB clock: drive inputs, advance the model across the edge, check outputs.
  task automatic step(input bit v, input logic [7:0] d, input bit sof, input bit stall,
                      input bit r, output bit acc);
    wr_t w;
    s_valid  = v;
    s_data   = d;
    s_sof    = sof;
    wr_stall = stall;
    rst      = r;
    acc      = v && !r && (exp_q.size() < DEPTH);
    @(posedge ahb_clk);
    if (r) begin
      exp_q.delete();
      m_bcnt      = 0;
      m_pix       = 0;
      m_fd        = 1'b0;
      m_after_rst = 1'b1;
      m_csum_acc  = 0;
      m_csum_frame = 0;
    end else begin
      m_after_rst = 1'b0;
      m_fd        = 1'b0;
      if (exp_q.size() != 0 && !stall) void'(exp_q.pop_front());
      if (acc) begin
        if (sof) begin
          m_bcnt     = 0;
          m_pix      = 0;
          m_csum_acc = 0;
        end
        m_bytes[m_bcnt] = d;
        m_bcnt++;
        m_csum_acc = (m_csum_acc + d) % 65536;
        if (m_bcnt == 3) begin
          w.addr = 32'(m_pix * 4);
          w.data = {m_bytes[0], m_bytes[1], m_bytes[2]};
          exp_q.push_back(w);
          m_bcnt = 0;
          m_pix++;
          if (m_pix == NPIX) begin
            m_pix        = 0;
            m_fd         = 1'b1;
            m_csum_frame = m_csum_acc;
            m_csum_acc   = 0;
          end
        end
      end
    end
    @(negedge ahb_clk);
    check_outputs();
  endtask

  // Offer one byte until accepted (bounded).
  task automatic send(input logic [7:0] d, input bit sof, input bit stall);
    bit acc = 1'b0;
    for (int c = 0; c < 100 && !acc; c++) step(1'b1, d, sof, stall, 1'b0, acc);
  endtask

  task automatic idle(input int n, input bit stall);
    bit acc;
    for (int c = 0; c < n; c++) step(1'b0, 8'h00, 1'b0, stall, 1'b0, acc);
  endtask

  // Random-data byte stream with random valid gaps and stalls; a byte is held until taken.
  task automatic stream(input int nbytes, input bit sof_first, input int vpct,
                        input int spct, input int max_cyc);
    int         sent = 0;
    bit         acc;
    bit         v;
    bit         st;
    logic [7:0] d = 8'($urandom);
    for (int c = 0; c < max_cyc && sent < nbytes; c++) begin
      v  = ($urandom_range(99) < vpct);
      st = ($urandom_range(99) < spct);
      step(v, d, (sof_first && sent == 0), st, 1'b0, acc);
      if (acc) begin
        sent++;
        d = 8'($urandom);
      end
    end
  endtask

  initial begin
    bit acc;
    int fd_before;

    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);

    // Two RGB pixels starting a frame
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    check_eq("px0_addr", wr_addr, 32'h0);
    check_eq("px0_data", wr_data, 24'h112233);
    send(8'h44, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    send(8'h66, 1'b0, 1'b0);
    check_eq("px1_addr", wr_addr, 32'h4);
    check_eq("px1_data", wr_data, 24'h445566);
    idle(3, 1'b0);
    check_eq("pix_count_two", pix_count, 2);

    // Partial pixel discarded by a new start of frame
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'hAA, 1'b1, 1'b0);
    send(8'hBB, 1'b0, 1'b0);
    send(8'hCC, 1'b0, 1'b0);
    check_eq("sof_addr", wr_addr, 32'h0);
    check_eq("sof_data", wr_data, 24'hAABBCC);
    idle(3, 1'b0);

    // Stall holds the head and back-pressures the source, then drains
    stream(15, 1'b1, 100, 100, 20);
    check_eq("stall_ready_low", s_ready, 1'b0);
    check_eq("stall_head_addr", wr_addr, 32'h0);
    stream(30, 1'b0, 100, 0, 200);
    idle(10, 1'b0);

    // Reset while three writes are pending behind a stall
    stream(9, 1'b1, 100, 100, 20);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, acc);
    check_eq("rst_wr_en", wr_en, 1'b0);
    check_eq("rst_pix_count", pix_count, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
    check_eq("rst_ready", s_ready, 1'b1);
    send(8'h5A, 1'b0, 1'b0);
    send(8'hA5, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0);
    check_eq("post_rst_addr", wr_addr, 32'h0);
    idle(3, 1'b0);

    // Full frame with random gaps and stalls
    fd_before = dut_fd_count;
    stream(3 * NPIX, 1'b1, 80, 25, 40000);
    idle(10, 1'b0);
    check_eq("frame_done_once", dut_fd_count - fd_before, 1);
    check_eq("frame_pix_wrap", pix_count, 0);

    // Random stress with occasional start-of-frame and reset
    for (int c = 0; c < 2000; c++) begin
      step(($urandom_range(99) < 70), 8'($urandom), ($urandom_range(99) < 3),
           ($urandom_range(99) < 30), ($urandom_range(999) < 5), acc);
    end

    // Gray instance: one byte per pixel
    @(negedge ahb_clk);
    g_rst = 1'b1;
    @(posedge ahb_clk);
    @(negedge ahb_clk);
    g_rst = 1'b0;
    check_eq("g_rst_wr_en", g_wr_en, 1'b0);
    check_eq("g_rst_pix", g_pix_count, 0);
    for (int i = 1; i <= 4; i++) begin
      g_valid = 1'b1;
      g_data  = 8'(i);
      g_sof   = (i == 1);
      @(posedge ahb_clk);
      @(negedge ahb_clk);
      check_eq("g_wr_en", g_wr_en, 1'b1);
      check_eq("g_wr_addr", g_wr_addr, 32'((i - 1) * 4));
      check_eq("g_wr_data", g_wr_data, 8'(i));
      check_eq("g_ready", g_ready, 1'b1);
    end
    g_valid = 1'b0;
    g_sof   = 1'b0;
    @(posedge ahb_clk);
    @(negedge ahb_clk);
    check_eq("g_drained", g_wr_en, 1'b0);
    check_eq("g_pix_count", g_pix_count, 4);

    // Gray full frame of 0x01 bytes
    for (int i = 0; i < NPIX; i++) begin
      g_valid = 1'b1;
      g_data  = 8'h01;
      g_sof   = (i == 0);
      @(posedge ahb_clk);
      @(negedge ahb_clk);
      if (i == NPIX - 2) check_eq("g_fd_early", g_frame_done, 1'b0);
    end
    g_valid = 1'b0;
    g_sof   = 1'b0;
    check_eq("g_frame_done", g_frame_done, 1'b1);
    check_eq("g_last_addr", g_wr_addr, 32'h23FC);
    check_eq("g_pix_wrap", g_pix_count, 0);
`ifdef VGA_FB_LOADER_CHECKSUM_EN
    check_eq("g_frame_csum", g_frame_csum, 16'h0900);
`endif
    @(posedge ahb_clk);
    @(negedge ahb_clk);
    check_eq("g_fd_pulse", g_frame_done, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
